vend_change: RTL and testbench

//  Parametrised newspaper vending controller with configurable price, coin set and change return.

---
 rtl/vend_change.sv | 111 +++++++++++
 tb/tb_vend_change.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change.sv
// rtl/vend_change.sv - newspaper vending controller: coin credit, vend, nickel change return
// Optional saturating sales counter is enabled by defining VEND_SALES_CNT_EN.
module vend_change #(
  parameter int PRICE    = 15,
  parameter int DIME_VAL = 10,
  parameter int QTR_VAL  = 25,
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                newspaper,
  output logic                change_nickel,
  output logic                busy,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sales_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(DIME_VAL);
  localparam logic [CREDIT_W-1:0] QTR_C    = CREDIT_W'(QTR_VAL);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx, coin_val, sum;
  logic                reject_nx;
  logic                newspaper_nx, change_nx, busy_nx;

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = NICKEL_C;
      2'b10:   coin_val = DIME_C;
      2'b11:   coin_val = QTR_C;
      default: coin_val = '0;
    endcase
  end

  assign sum = credit + coin_val;

  // Outputs are registered from the next state so every output is a clean flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      credit        <= '0;
      coin_reject   <= 1'b0;
      newspaper     <= 1'b0;
      change_nickel <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      credit        <= credit_nx;
      coin_reject   <= reject_nx;
      newspaper     <= newspaper_nx;
      change_nickel <= change_nx;
      busy          <= busy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    reject_nx = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (state == ACCUM && cancel) begin
          state_nx  = CHANGE;
          reject_nx = (coin != 2'b00);
        end else if (coin != 2'b00) begin
          credit_nx = sum;
          state_nx  = (sum >= PRICE_C) ? VEND : ACCUM;
        end
      end
      VEND: begin
        credit_nx = credit - PRICE_C;
        state_nx  = (credit == PRICE_C) ? IDLE : CHANGE;
        reject_nx = (coin != 2'b00);
      end
      CHANGE: begin
        credit_nx = credit - NICKEL_C;
        state_nx  = (credit == NICKEL_C) ? IDLE : CHANGE;
        reject_nx = (coin != 2'b00);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    newspaper_nx = (state_nx == VEND);
    change_nx    = (state_nx == CHANGE);
    busy_nx      = (state_nx == VEND) || (state_nx == CHANGE);
  end

`ifdef VEND_SALES_CNT_EN
  // VEND lasts exactly one cycle, so a next state of VEND is always a fresh entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      sales_count <= '0;
    else if (state_nx == VEND && sales_count != '1)
      sales_count <= sales_count + 1'b1;
  end
`else
  assign sales_count = '0;
`endif

endmodule

// File: tb/tb_vend_change.sv
// tb/tb_vend_change.sv - randomized and directed self-checking bench for vend_change
// Expected sales_count follows VEND_SALES_CNT_EN.
module tb_vend_change;
  localparam int PRICE = 15;
  localparam int DIME  = 10;
  localparam int QTR   = 25;
  localparam int CW    = 8;
  localparam int NW    = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic          cancel = 1'b0;
  logic          newspaper, change_nickel, busy, coin_reject;
  logic [CW-1:0] credit;
  logic [NW-1:0] sales_count;

  int n_assert = 0;
  int n_fail = 0;
  int np_cnt = 0, cn_cnt = 0;

  // model: credit in cents plus what the machine is currently doing with it
  int m_credit = 0;
  bit m_vend = 0, m_refund = 0, m_rej = 0;
  int m_sales = 0;

  vend_change #(.PRICE(PRICE), .DIME_VAL(DIME), .QTR_VAL(QTR), .CREDIT_W(CW), .CNT_W(NW)) dut (
    .clock(clock), .reset_n(reset_n), .coin(coin), .cancel(cancel),
    .newspaper(newspaper), .change_nickel(change_nickel), .busy(busy),
    .coin_reject(coin_reject), .credit(credit), .sales_count(sales_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int value_of(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return DIME;
      2'b11:   return QTR;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_credit = 0; m_vend = 0; m_refund = 0; m_rej = 0; m_sales = 0;
    end else begin
      bit rej;
      rej = 0;
      if (m_vend) begin
        rej = (coin != 0);
        m_credit -= PRICE;
        m_vend = 0;
        m_refund = (m_credit > 0);
      end else if (m_refund) begin
        rej = (coin != 0);
        m_credit -= 5;
        if (m_credit == 0) m_refund = 0;
      end else if (m_credit > 0 && cancel) begin
        rej = (coin != 0);
        m_refund = 1;
      end else if (coin != 0) begin
        m_credit += value_of(coin);
        if (m_credit >= PRICE) begin
          m_vend = 1;
`ifdef VEND_SALES_CNT_EN
          if (m_sales < (1 << NW) - 1) m_sales++;
`endif
        end
      end
      m_rej = rej;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("newspaper", int'(newspaper), int'(m_vend));
      chk("change_nickel", int'(change_nickel), int'(m_refund));
      chk("busy", int'(busy), int'(m_vend | m_refund));
      chk("coin_reject", int'(coin_reject), int'(m_rej));
      chk("credit", int'(credit), m_credit);
      chk("sales_count", int'(sales_count), m_sales);
      np_cnt += int'(newspaper);
      cn_cnt += int'(change_nickel);
    end
  end

  task automatic cyc(input logic [1:0] c, input logic k);
    coin = c;
    cancel = k;
    @(posedge clock);
    #1;
    coin = 2'b00;
    cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int np0, cn0;
    int exp_sales [4];
`ifdef VEND_SALES_CNT_EN
    exp_sales = '{1, 2, 3, 3};
`else
    exp_sales = '{0, 0, 0, 0};
`endif
    #1;
    chk("reset_credit", int'(credit), 0);
    chk("reset_flags", int'({newspaper, change_nickel, busy, coin_reject}), 0);
    chk("reset_sales", int'(sales_count), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    // three nickels: vend right after the third, no change
    np0 = np_cnt; cn0 = cn_cnt;
    cyc(2'b01, 0); cyc(2'b01, 0); cyc(2'b01, 0);
    chk("n3_newspaper", int'(newspaper), 1);
    chk("n3_credit_vend", int'(credit), 15);
    idle(4);
    chk("n3_np_count", np_cnt - np0, 1);
    chk("n3_cn_count", cn_cnt - cn0, 0);
    chk("n3_credit", int'(credit), 0);

    // quarter: vend then exactly two nickels, 25 -> 10 -> 5 -> 0
    np0 = np_cnt; cn0 = cn_cnt;
    cyc(2'b11, 0);
    chk("q_newspaper", int'(newspaper), 1);
    chk("q_credit25", int'(credit), 25);
    idle(1);
    chk("q_credit10", int'(credit), 10);
    chk("q_change", int'(change_nickel), 1);
    idle(1);
    chk("q_credit5", int'(credit), 5);
    idle(1);
    chk("q_credit0", int'(credit), 0);
    chk("q_busy_off", int'(busy), 0);
    idle(2);
    chk("q_cn_count", cn_cnt - cn0, 2);

    // nickel then cancel: full refund, no newspaper
    np0 = np_cnt; cn0 = cn_cnt;
    cyc(2'b01, 0); cyc(2'b00, 1);
    idle(3);
    chk("cancel_np", np_cnt - np0, 0);
    chk("cancel_cn", cn_cnt - cn0, 1);
    chk("cancel_credit", int'(credit), 0);

    // cancel and dime together in ACCUM: dime refused, refund 5 only
    cn0 = cn_cnt;
    cyc(2'b01, 0); cyc(2'b10, 1);
    chk("cd_reject", int'(coin_reject), 1);
    chk("cd_credit", int'(credit), 5);
    idle(3);
    chk("cd_cn", cn_cnt - cn0, 1);

    // dime+dime vends with 5 owed; dime during CHANGE refused
    np0 = np_cnt; cn0 = cn_cnt;
    cyc(2'b10, 0); cyc(2'b10, 0);
    chk("dd_credit20", int'(credit), 20);
    idle(1);
    chk("dd_change", int'(change_nickel), 1);
    cyc(2'b10, 0);
    chk("dd_reject", int'(coin_reject), 1);
    chk("dd_credit0", int'(credit), 0);
    idle(3);
    chk("dd_np", np_cnt - np0, 1);
    chk("dd_cn", cn_cnt - cn0, 1);

    // asynchronous reset mid-CHANGE clears everything without an edge
    cyc(2'b11, 0); idle(1);
    chk("ar_credit_pre", int'(credit), 10);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_credit", int'(credit), 0);
    chk("ar_flags", int'({newspaper, change_nickel, busy, coin_reject}), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(2);

    // four vends for the sales counter
    do_reset();
    for (int v = 0; v < 4; v++) begin
      cyc(2'b01, 0); cyc(2'b01, 0); cyc(2'b01, 0);
      idle(2);
      chk("sales_step", int'(sales_count), exp_sales[v]);
    end

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] c;
      logic k;
      c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      k = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(c, k);
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
